// File: rtl/dram_slot_arbiter.sv
// DRAM slot arbiter: runs the 4-fclk cycle rotation, picks one owner per DRAM
// cycle (refresh, video, Z80, DMA) and forwards its access to the controller.
module dram_slot_arbiter #(
  parameter int unsigned REFR_PERIOD = 64,
  parameter int unsigned DMA_STARVE  = 4
) (
  input  logic        fclk,
  input  logic        rst_n,
  output logic        cbeg,
  output logic        post_cbeg,
  output logic        pre_cend,
  output logic        cend,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_wrbsel,
  output logic        cpu_next,
  output logic        cpu_strobe,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_next,
  output logic        vid_strobe,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [20:0] dma_addr,
  input  logic [15:0] dma_wrdata,
  input  logic [1:0]  dma_bsel,
  output logic        dma_next,
  output logic        dma_strobe,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [15:0] dram_wrdata,
  output logic [1:0]  dram_bsel,
  output logic        dram_rfsh
);

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 7;
  localparam int unsigned SW = $clog2(DMA_STARVE + 1);

  // One-hot phase encoding; all-zero is the post-reset state before the first cbeg.
  typedef enum logic [3:0] {
    PH_RST  = 4'b0000,
    PH_CBEG = 4'b0001,
    PH_POST = 4'b0010,
    PH_PRE  = 4'b0100,
    PH_CEND = 4'b1000
  } phase_e;

  typedef enum logic [2:0] {
    OWN_IDLE = 3'd0,
    OWN_RFSH = 3'd1,
    OWN_VID  = 3'd2,
    OWN_CPU  = 3'd3,
    OWN_DMA  = 3'd4
  } owner_e;

  phase_e          phase_q, phase_d;
  owner_e          own_q, own_d, win;
  logic            req_q, req_d;
  logic            rfsh_q, rfsh_d;
  logic            rnw_q, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [1:0]      bsel_q, bsel_d;
  logic            cpu_stb_q, cpu_stb_d;
  logic            vid_stb_q, vid_stb_d;
  logic            dma_stb_q, dma_stb_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            rpend_q, rpend_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            cend_c;
  logic            starved_c;

  assign cbeg      = (phase_q == PH_CBEG);
  assign post_cbeg = (phase_q == PH_POST);
  assign pre_cend  = (phase_q == PH_PRE);
  assign cend      = (phase_q == PH_CEND);
  assign cend_c    = cend;
  assign starved_c = (scnt_q == SW'(DMA_STARVE));

  // Phase rotation next-state.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_RST:  phase_d = PH_CBEG;
      PH_CBEG: phase_d = PH_POST;
      PH_POST: phase_d = PH_PRE;
      PH_PRE:  phase_d = PH_CEND;
      PH_CEND: phase_d = PH_CBEG;
      default: phase_d = PH_CBEG;
    endcase
  end

  // Priority pick; a slot is only granted to a requester that is asking.
  always_comb begin
    win = OWN_IDLE;
    if (rpend_q)                    win = OWN_RFSH;
    else if (vid_req)               win = OWN_VID;
    else if (dma_req && starved_c)  win = OWN_DMA;
    else if (cpu_req)               win = OWN_CPU;
    else if (dma_req)               win = OWN_DMA;
  end

  // Look-ahead grants must be seen by requesters inside the cend cycle, so they are combinational.
  assign vid_next = cend_c & ~rpend_q;
  assign cpu_next = cend_c & ~rpend_q & ~vid_req & ~(dma_req & starved_c);
  assign dma_next = cend_c & ~rpend_q & ~vid_req & dma_req & (starved_c | ~cpu_req);

  // Slot contents for the next DRAM cycle, captured on the cend edge.
  always_comb begin
    own_d  = own_q;
    req_d  = req_q;
    rfsh_d = rfsh_q;
    rnw_d  = rnw_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    bsel_d = bsel_q;
    if (cend_c) begin
      own_d  = win;
      req_d  = 1'b0;
      rfsh_d = 1'b0;
      rnw_d  = 1'b0;
      addr_d = '0;
      wd_d   = '0;
      bsel_d = '0;
      unique case (win)
        OWN_RFSH: rfsh_d = 1'b1;
        OWN_VID: begin
          req_d  = 1'b1;
          rnw_d  = 1'b1;
          addr_d = vid_addr;
          bsel_d = 2'b11;
        end
        OWN_CPU: begin
          req_d  = 1'b1;
          rnw_d  = cpu_rnw;
          addr_d = cpu_addr;
          wd_d   = {cpu_wrdata, cpu_wrdata};
          bsel_d = cpu_rnw ? 2'b11 : {~cpu_wrbsel, cpu_wrbsel};
        end
        OWN_DMA: begin
          req_d  = 1'b1;
          rnw_d  = dma_rnw;
          addr_d = dma_addr;
          wd_d   = dma_wrdata;
          bsel_d = dma_bsel;
        end
        default: ;
      endcase
    end
  end

  // Read-data strobes land on the owner's cend cycle.
  always_comb begin
    cpu_stb_d = 1'b0;
    vid_stb_d = 1'b0;
    dma_stb_d = 1'b0;
    if ((phase_q == PH_PRE) && req_q && rnw_q) begin
      cpu_stb_d = (own_q == OWN_CPU);
      vid_stb_d = (own_q == OWN_VID);
      dma_stb_d = (own_q == OWN_DMA);
    end
  end

  // Refresh interval and DMA starvation bookkeeping, advanced once per DRAM cycle.
  always_comb begin
    rcnt_d  = rcnt_q;
    rpend_d = rpend_q;
    scnt_d  = scnt_q;
    if (cend_c) begin
      if (win == OWN_RFSH) rpend_d = 1'b0;
      if (rcnt_q == RW'(REFR_PERIOD - 1)) begin
        rcnt_d  = '0;
        rpend_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
      if (!dma_req || (win == OWN_DMA)) scnt_d = '0;
      else if (!starved_c)              scnt_d = scnt_q + SW'(1);
    end
  end

  // State registers.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_RST;
      own_q     <= OWN_IDLE;
      req_q     <= 1'b0;
      rfsh_q    <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      bsel_q    <= '0;
      cpu_stb_q <= 1'b0;
      vid_stb_q <= 1'b0;
      dma_stb_q <= 1'b0;
      rcnt_q    <= '0;
      rpend_q   <= 1'b0;
      scnt_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      own_q     <= own_d;
      req_q     <= req_d;
      rfsh_q    <= rfsh_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      bsel_q    <= bsel_d;
      cpu_stb_q <= cpu_stb_d;
      vid_stb_q <= vid_stb_d;
      dma_stb_q <= dma_stb_d;
      rcnt_q    <= rcnt_d;
      rpend_q   <= rpend_d;
      scnt_q    <= scnt_d;
    end
  end

  assign dram_req    = req_q;
  assign dram_rfsh   = rfsh_q;
  assign dram_rnw    = rnw_q;
  assign dram_addr   = addr_q;
  assign dram_wrdata = wd_q;
  assign dram_bsel   = bsel_q;
  assign cpu_strobe  = cpu_stb_q;
  assign vid_strobe  = vid_stb_q;
  assign dma_strobe  = dma_stb_q;

endmodule

// File: tb/tb_dram_slot_arbiter.sv
// Randomized bench for dram_slot_arbiter against a slot-level reference model.
module tb_dram_slot_arbiter;

  localparam int unsigned RP = 64;
  localparam int unsigned DS = 4;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        cbeg, post_cbeg, pre_cend, cend;
  logic        cpu_req, cpu_rnw, cpu_wrbsel, cpu_next, cpu_strobe;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        vid_req, vid_next, vid_strobe;
  logic [20:0] vid_addr;
  logic        dma_req, dma_rnw, dma_next, dma_strobe;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic [1:0]  dma_bsel;
  logic        dram_req, dram_rnw, dram_rfsh;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata;
  logic [1:0]  dram_bsel;

  dram_slot_arbiter #(.REFR_PERIOD(RP), .DMA_STARVE(DS)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .cbeg(cbeg), .post_cbeg(post_cbeg), .pre_cend(pre_cend), .cend(cend),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
    .cpu_wrbsel(cpu_wrbsel), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_next(vid_next), .vid_strobe(vid_strobe),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_bsel(dma_bsel), .dma_next(dma_next), .dma_strobe(dma_strobe),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel), .dram_rfsh(dram_rfsh)
  );

  always #5 fclk = ~fclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner codes 0 idle, 1 refresh, 2 video, 3 cpu, 4 dma.
  int          k;
  int          ncend;
  bit          pend;
  int          lost;
  int          e_own;
  bit          e_req, e_rfsh, e_rnw;
  logic [20:0] e_addr;
  logic [15:0] e_wd;
  logic [1:0]  e_bsel;
  int          pc, pv, pd;
  int          n_rfsh, n_cpu, n_dma, n_vid;

  task automatic reset_model();
    k = 0; ncend = 0; pend = 0; lost = 0;
    e_own = 0; e_req = 0; e_rfsh = 0; e_rnw = 0; e_addr = '0; e_wd = '0; e_bsel = '0;
  endtask

  task automatic new_stim(input int gw);
    if (gw == 3 || !cpu_req) begin
      cpu_req    = ($urandom_range(99) < pc);
      cpu_rnw    = 1'($urandom_range(1));
      cpu_addr   = 21'($urandom);
      cpu_wrdata = 8'($urandom);
      cpu_wrbsel = 1'($urandom_range(1));
    end
    if (gw == 2 || !vid_req) begin
      vid_req  = ($urandom_range(99) < pv);
      vid_addr = 21'($urandom);
    end
    if (gw == 4 || !dma_req) begin
      dma_req    = ($urandom_range(99) < pd);
      dma_rnw    = 1'($urandom_range(1));
      dma_addr   = 21'($urandom);
      dma_wrdata = 16'($urandom);
      dma_bsel   = 2'($urandom);
    end
  endtask

  // One fclk: check at the falling edge, settle the model on cend, then move stimulus.
  task automatic tick();
    int ph, gw;
    bit starved, x_cn, x_vn, x_dn;
    logic [3:0] x_ph;
    logic [2:0] x_stb;
    @(negedge fclk);
    ph   = (k == 0) ? -1 : (k - 1) % 4;
    x_ph = (k == 0) ? 4'b0000 : (4'b1000 >> ph);
    check("phase", {cbeg, post_cbeg, pre_cend, cend}, x_ph);
    check("slot_ctl", {dram_req, dram_rfsh, dram_rnw}, {e_req, e_rfsh, e_rnw});
    check("slot_addr", dram_addr, e_addr);
    check("slot_wd", dram_wrdata, e_wd);
    check("slot_bsel", dram_bsel, e_bsel);
    x_stb = 3'b000;
    if (ph == 3 && e_req && e_rnw)
      x_stb = {e_own == 3, e_own == 2, e_own == 4};
    check("strobes", {cpu_strobe, vid_strobe, dma_strobe}, x_stb);
    gw = -1;
    x_cn = 0; x_vn = 0; x_dn = 0;
    if (ph == 3) begin
      starved = (lost >= DS);
      if (pend)                    gw = 1;
      else if (vid_req)            gw = 2;
      else if (dma_req && starved) gw = 4;
      else if (cpu_req)            gw = 3;
      else if (dma_req)            gw = 4;
      else                         gw = 0;
      x_vn = !pend;
      x_cn = !pend && !vid_req && !(dma_req && starved);
      x_dn = !pend && !vid_req && dma_req && (starved || !cpu_req);
    end
    check("next", {cpu_next, vid_next, dma_next}, {x_cn, x_vn, x_dn});
    if (ph == 3) begin
      e_own = gw; e_req = 0; e_rfsh = 0; e_rnw = 0; e_addr = '0; e_wd = '0; e_bsel = '0;
      case (gw)
        1: begin e_rfsh = 1; n_rfsh++; end
        2: begin e_req = 1; e_rnw = 1; e_addr = vid_addr; e_bsel = 2'b11; n_vid++; end
        3: begin
          e_req = 1; e_rnw = cpu_rnw; e_addr = cpu_addr; e_wd = {cpu_wrdata, cpu_wrdata};
          e_bsel = cpu_rnw ? 2'b11 : {~cpu_wrbsel, cpu_wrbsel}; n_cpu++;
        end
        4: begin
          e_req = 1; e_rnw = dma_rnw; e_addr = dma_addr; e_wd = dma_wrdata; e_bsel = dma_bsel;
          n_dma++;
        end
        default: ;
      endcase
      if (gw == 1) pend = 0;
      ncend++;
      if (ncend % RP == 0) pend = 1;
      if (!dma_req || gw == 4) lost = 0;
      else if (lost < DS)      lost++;
    end
    @(posedge fclk);
    k++;
    #1;
    new_stim(gw);
  endtask

  initial begin
    bit found;
    int c0, d0;
    cpu_req = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wrdata = '0; cpu_wrbsel = 0;
    vid_req = 0; vid_addr = '0;
    dma_req = 0; dma_rnw = 0; dma_addr = '0; dma_wrdata = '0; dma_bsel = '0;
    n_rfsh = 0; n_cpu = 0; n_dma = 0; n_vid = 0;
    pc = 0; pv = 0; pd = 0;
    rst_n = 0;
    reset_model();
    #12;
    check("rst_all", {cbeg, post_cbeg, pre_cend, cend, dram_req, dram_rfsh, cpu_strobe,
                      vid_strobe, dma_strobe, dram_rnw, dram_bsel}, 32'h0);
    @(posedge fclk); #1;
    rst_n = 1;
    reset_model();

    // Idle long enough to see several refresh slots.
    repeat (4 * RP * 3 + 8) tick();
    check("rfsh_count_idle", n_rfsh, 3);

    // Mixed random traffic.
    pc = 60; pv = 15; pd = 40;
    repeat (2000) tick();

    // CPU and DMA both saturated: 4 CPU then 1 DMA per round, apart from refresh.
    pc = 100; pv = 0; pd = 100;
    repeat (8) tick();
    c0 = n_cpu; d0 = n_dma;
    repeat (4 * 40) tick();
    check("sat_dma_share", ((n_dma - d0) >= 7) && ((n_dma - d0) <= 9), 1);
    check("sat_cpu_share", ((n_cpu - c0) >= 30) && ((n_cpu - c0) <= 33), 1);

    // Reset in the pre_cend cycle of a CPU read slot.
    pc = 0; pd = 0; pv = 0;
    repeat (8) tick();
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h12345;
    pc = 100;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      cpu_rnw = 1;
      if (e_own == 3 && e_rnw && k > 0 && ((k - 1) % 4) == 2) found = 1;
    end
    check("rst_slot_found", found, 1);
    check("rst_pre_addr", dram_addr, 21'h12345);
    #2;
    rst_n = 0;
    #1;
    check("rst_mid", {cbeg, post_cbeg, pre_cend, cend, dram_req, dram_rfsh, cpu_strobe,
                      dram_rnw, dram_bsel, 16'(dram_addr)}, 32'h0);
    @(posedge fclk); #1;
    check("rst_hold", {cbeg, cend, cpu_strobe, vid_strobe, dma_strobe, cpu_next}, 32'h0);
    rst_n = 1;
    reset_model();
    pc = 60; pv = 15; pd = 40;
    repeat (400) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
